// File: rtl/timekeeper_core.sv
// Board timekeeper: 1 Hz divider, hh:mm:ss timebase with set mode, 12/24 h BCD display and hh:mm alarm.
// Time is held in binary internally; BCD conversion is purely combinational on the output side.
module timekeeper_core #(
  parameter int TICK_DIV = 100000000,
  parameter int DIV_W    = 27
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        on,
  input  logic        mode_24h,
  input  logic        inc,
  input  logic        dec,
  input  logic        sel_l,
  input  logic        sel_r,
  input  logic        alarm_en,
  input  logic [4:0]  alarm_hr,
  input  logic [5:0]  alarm_min,
  output logic [23:0] digits,
  output logic        pm,
  output logic [1:0]  field,
  output logic        tick_1hz,
  output logic        alarm_hit
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       sec, min;
  logic [4:0]       hr;

  logic             terminal;
  logic             sec_wrap, min_wrap;
  logic [5:0]       sec_nx, min_nx;
  logic [4:0]       hr_nx;
  logic             step_up, step_dn;
  logic [4:0]       hr_disp;

  function automatic logic [5:0] up_wrap6(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dn_wrap6(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  assign terminal = (div_cnt == DIV_LAST);

  // Next time for a run-mode tick, with full carry chain resolved in one cycle.
  assign sec_wrap = (sec == 6'd59);
  assign min_wrap = (min == 6'd59);
  assign sec_nx   = sec_wrap ? 6'd0 : sec + 6'd1;
  assign min_nx   = sec_wrap ? (min_wrap ? 6'd0 : min + 6'd1) : min;
  assign hr_nx    = (sec_wrap && min_wrap) ? ((hr == 5'd23) ? 5'd0 : hr + 5'd1) : hr;

  // Simultaneous inc and dec cancel out.
  assign step_up = inc & ~dec;
  assign step_dn = dec & ~inc;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      div_cnt   <= '0;
      sec       <= 6'd0;
      min       <= 6'd0;
      hr        <= 5'd0;
      field     <= 2'd0;
      tick_1hz  <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      tick_1hz  <= 1'b0;
      alarm_hit <= 1'b0;
      if (on) begin
        if (terminal) begin
          div_cnt   <= '0;
          tick_1hz  <= 1'b1;
          sec       <= sec_nx;
          min       <= min_nx;
          hr        <= hr_nx;
          alarm_hit <= alarm_en && (hr_nx == alarm_hr) && (min_nx == alarm_min)
                       && (sec_nx == 6'd0);
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        if (step_up || step_dn) begin
          case (field)
            2'd0:    sec <= step_up ? up_wrap6(sec, 6'd59) : dn_wrap6(sec, 6'd59);
            2'd1:    min <= step_up ? up_wrap6(min, 6'd59) : dn_wrap6(min, 6'd59);
            2'd2: begin
              if (step_up) hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
              else         hr <= (hr == 5'd0) ? 5'd23 : hr - 5'd1;
            end
            default: ;
          endcase
        end
        if (sel_l && !sel_r)      field <= (field == 2'd2) ? 2'd0 : field + 2'd1;
        else if (sel_r && !sel_l) field <= (field == 2'd0) ? 2'd2 : field - 2'd1;
      end
    end
  end

  always_comb begin
    hr_disp = hr;
    if (!mode_24h) begin
      if (hr == 5'd0)       hr_disp = 5'd12;
      else if (hr > 5'd12)  hr_disp = hr - 5'd12;
    end
  end

  assign pm     = !mode_24h && (hr >= 5'd12);
  assign digits = {to_bcd({1'b0, hr_disp}), to_bcd(min), to_bcd(sec)};

endmodule

// File: doc/timekeeper_core.md
Name: timekeeper_core

Overview:
- Parametrised successor to the button-adjustable board clock.
- Holds seconds, minutes and hours in one registered timebase and advances them from an internal 1 Hz tick divider.
- Supports a set mode with field select and inc/dec, runtime 12/24-hour display mode, and an hh:mm alarm compare.
- Sits between the debounced/edge-detected button pulses and the seven-segment driver; emits BCD digits.

Parameters:
TICK_DIV, 100000000, CLK100MHZ cycles per 1 s tick (min 2)
DIV_W, 27, width of the tick divider counter (must hold TICK_DIV-1)

Ports:
CLK100MHZ  input  1  system clock
rst  input  1  synchronous active-high reset
on  input  1  1 = run (time advances), 0 = set mode
mode_24h  input  1  1 = 24 h display, 0 = 12 h display
inc  input  1  single-cycle pulse: increment selected field
dec  input  1  single-cycle pulse: decrement selected field
sel_l  input  1  single-cycle pulse: select next field (sec->min->hr->sec)
sel_r  input  1  single-cycle pulse: select previous field
alarm_en  input  1  alarm compare enable
alarm_hr  input  5  alarm hour, binary 0..23
alarm_min  input  6  alarm minute, binary 0..59
digits  output  24  BCD {hr10,hr1,min10,min1,sec10,sec1}, 4 bits each
pm  output  1  PM indicator (12 h mode only, else 0)
field  output  2  selected field: 0 = sec, 1 = min, 2 = hr
tick_1hz  output  1  one-cycle pulse on each divider terminal count
alarm_hit  output  1  one-cycle pulse on alarm match

Behaviour:
- Reset (sync, rst=1 at edge): sec=0, min=0, hr=0 (internal binary 0..23), divider=0, field=0, tick_1hz=0, alarm_hit=0. rst overrides all other inputs in the same cycle.
- Divider:
  - While on=1, counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and tick_1hz is registered high for the next cycle.
  - While on=0, divider is held at 0, so the first second after resuming is a full TICK_DIV cycles.
- Run mode (on=1):
  - On each tick, sec increments. 59->0 carries to min, 59->0 carries to hr, 23->0.
  - All fields update in one cycle; outputs are registered and visible the cycle after the terminal count.
  - inc/dec/sel_l/sel_r are ignored.
- Set mode (on=0):
  - sel_l: field = (field==2) ? 0 : field+1.
  - sel_r: field = (field==0) ? 2 : field-1.
  - sel_l and sel_r in the same cycle: field unchanged.
  - inc/dec act on the selected field only, with wrap and no carry: sec/min 59<->0, hr 23<->0.
  - inc and dec in the same cycle: no change.
  - sel and inc/dec in the same cycle: inc/dec applies to the old field; field updates after.
- Mode transitions: on 1->0 takes effect in the same cycle; a tick coinciding with on=0 is discarded. Time is preserved across transitions.
- Display (combinational from registers, no added latency):
  - mode_24h=1: hours shown 00..23, pm=0.
  - mode_24h=0: hr 0 -> 12, 1..11 -> 1..11, 12 -> 12, 13..23 -> 1..11; pm = (hr>=12). hr10 digit is 0 or 1.
  - Toggling mode_24h never alters stored time.
- Alarm:
  - alarm_hit pulses exactly one cycle when alarm_en=1, on=1, and a tick produces hr==alarm_hr, min==alarm_min, sec==0.
  - Edits in set mode never trigger the alarm.
  - alarm_hr/alarm_min out of range simply never match.

Test Plan:
- TICK_DIV=4, rst then on=1 for 16 cycles -> tick_1hz pulses every 4 cycles; digits = 0x000004.
- Load 23:59:58 via set mode, on=1, 2 ticks -> 23:59:59, then 00:00:00 in one cycle, no intermediate values.
- on=0, field=0, sec=59, inc -> sec=00 with min unchanged. dec from 00 -> 59. inc+dec same cycle -> unchanged.
- sel_r from field 0 -> field 2. sel_l from 2 -> 0. sel_l+sel_r together -> unchanged. Pulses with on=1 -> ignored.
- mode_24h=0: hr=0 -> digits hr "12", pm=0. hr=13 -> "01", pm=1. hr=12 -> "12", pm=1. Toggle back to 24 h -> "13".
- alarm 07:30, alarm_en=1, time 07:29:59, tick -> alarm_hit high one cycle. Set 07:30:00 manually -> no pulse. rst mid-count -> all outputs 0 next cycle.
